csr_trap_seq: RTL
=================

// Module: csr_trap_seq
// PURPOSE
//  Sequencer and arbiter in front of the single-port machine CSR file.
//  - Turns exception, interrupt and MRET events into ordered CSR read/write
//    sequences on mstatus, mepc, mcause, mtvec.
//  - Shares the CSR port with pipeline CSR instructions.
//  - Drives the fetch redirect (trap vector / mepc) and a pipeline stall.
// PARAMETERS
//  XLEN     32  data/address width
//  CAUSE_W  5   width of exception/interrupt cause code
//  VEC_EN   1   1: honour mtvec.MODE=1 vectored interrupts; 0: always direct
// PORTS
//  clk_i            in   1        clock
//  rst_ni           in   1        async active-low reset
//  exc_i            in   1        synchronous exception request (level, held while busy_o)
//  exc_cause_i      in   CAUSE_W  exception cause
//  exc_pc_i         in   XLEN     PC of faulting instruction
//  irq_i            in   1        interrupt pending (level)
//  irq_cause_i      in   CAUSE_W  interrupt cause (3/7/11)
//  irq_pc_i         in   XLEN     PC to resume after interrupt
//  irq_ack_o        out  1        1-cycle pulse: interrupt taken
//  mret_i           in   1        MRET retiring (level, held while busy_o)
//  csr_req_i        in   1        pipeline CSR access request
//  csr_we_i         in   1        pipeline CSR write
//  csr_re_i         in   1        pipeline CSR read
//  csr_idx_i        in   12       pipeline CSR address
//  csr_wdata_i      in   XLEN     pipeline CSR write data
//  csr_gnt_o        out  1        pipeline access granted this cycle
//  csr_rdata_o      out  XLEN     pipeline read data
//  cf_rd_en_o       out  1        to CSR file: read enable
//  cf_wr_en_o       out  1        to CSR file: write enable
//  cf_idx_o         out  12       to CSR file: address
//  cf_wdata_o       out  XLEN     to CSR file: write data
//  cf_rdata_i       in   XLEN     from CSR file: combinational read data
//  busy_o           out  1        sequence in progress; pipeline must stall
//  redir_valid_o    out  1        1-cycle redirect pulse
//  redir_pc_o       out  XLEN     redirect target
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; internal captures cleared.
//  Reset mid-sequence: aborts at once. CSR writes already issued stay; no redirect.
//  States: IDLE, RD_MST, WR_MST, WR_MEPC, WR_MCAUSE, RD_MTVEC, RD_MEPC, REDIR.
//  Events are sampled only in IDLE.
//  Priority: exc_i > irq_i > mret_i > csr_req_i.
//  IDLE:
//  - No event: csr_gnt_o = csr_req_i, same cycle.
//  - cf_* is the combinational pass-through of csr_*.
//  - csr_rdata_o = cf_rdata_i if granted and csr_re_i, else 0.
//  Event accepted at edge N:
//  - Capture cause, PC and type; next state RD_MST; csr_gnt_o=0.
//  - Exception mcause = {0, cause}; interrupt mcause = {1, cause}, bit XLEN-1 set.
//  RD_MST: cf_rd_en_o=1, idx 0x300; latch mstatus.
//  - Interrupt with latched MIE(bit3)=0: back to IDLE; no writes, no irq_ack_o.
//  WR_MST, trap: write mstatus with MPIE(7)=MIE, MIE(3)=0, MPP(12:11)=2'b11.
//  WR_MST, MRET: write mstatus with MIE=MPIE, MPIE=1, MPP=2'b11.
//  Trap path:
//  - WR_MEPC: write captured PC to 0x341, low bit forced to 0.
//  - WR_MCAUSE: write mcause to 0x342; irq_ack_o=1 here if interrupt.
//  - RD_MTVEC: latch 0x305.
//  - target = {mtvec[XLEN-1:2],2'b00}.
//  - If VEC_EN and mtvec[1:0]==1 and interrupt: target = base + (cause<<2).
//  MRET path: after WR_MST go to RD_MEPC; latch 0x341 as target.
//  REDIR: redir_valid_o=1, redir_pc_o=target, both registered; then IDLE.
//  - redir_pc_o is 0 whenever redir_valid_o=0.
//  Latency: trap redirect valid in cycle N+6; MRET in cycle N+4.
//  busy_o=1 in every state except IDLE.
//  Events in the same cycle: lower priority is dropped.
//  - Upstream re-presents it after busy_o falls.
//  At most one cf_rd_en_o/cf_wr_en_o active per cycle, never both.
// TESTING
//  1 CSR pass-through: IDLE, csr_req_i=1, we=1, idx=0x340, wdata=0xA5A5_A5A5
//    -> gnt=1, cf_wr_en_o=1 same cycle; read-back gives 0xA5A5_A5A5.
//  2 Exception: mtvec=0x8000_0100, exc cause=2, pc=0x1004
//    -> mepc=0x1004, mcause=0x2; mstatus MIE 1->0, MPIE=1;
//    -> redir_pc_o=0x8000_0100 in cycle N+6.
//  3 Vectored interrupt: mtvec=0x8000_0001, MIE=1, irq cause=7
//    -> mcause=0x8000_0007; irq_ack_o pulse; redir_pc_o=0x8000_001C.
//  4 Masked interrupt: MIE=0, irq_i=1 -> returns IDLE after RD_MST;
//    no write, no ack, no redirect.
//  5 MRET: mepc=0x2000, MPIE=1 -> MIE=1, MPIE=1; redir_pc_o=0x2000 at N+4.
//  6 Priority/reset: exc_i+irq_i+csr_req_i same cycle -> exception path, gnt=0;
//    rst_ni low in WR_MEPC -> outputs 0 immediately; mcause unchanged.

Source files
------------

// File: rtl/csr_trap_seq_if.sv
// Bundle between the trap/MRET sequencer, the pipeline and the machine CSR file.
// The sequencer uses the slave view; the environment uses the master view.
interface csr_trap_seq_if #(
    parameter int XLEN    = 32,
    parameter int CAUSE_W = 5
);
    // Trap and return events
    logic               exc_i;
    logic [CAUSE_W-1:0] exc_cause_i;
    logic [XLEN-1:0]    exc_pc_i;
    logic               irq_i;
    logic [CAUSE_W-1:0] irq_cause_i;
    logic [XLEN-1:0]    irq_pc_i;
    logic               irq_ack_o;
    logic               mret_i;
    // Pipeline CSR port
    logic               csr_req_i;
    logic               csr_we_i;
    logic               csr_re_i;
    logic [11:0]        csr_idx_i;
    logic [XLEN-1:0]    csr_wdata_i;
    logic               csr_gnt_o;
    logic [XLEN-1:0]    csr_rdata_o;
    // CSR file port
    logic               cf_rd_en_o;
    logic               cf_wr_en_o;
    logic [11:0]        cf_idx_o;
    logic [XLEN-1:0]    cf_wdata_o;
    logic [XLEN-1:0]    cf_rdata_i;
    // Pipeline control
    logic               busy_o;
    logic               redir_valid_o;
    logic [XLEN-1:0]    redir_pc_o;

    modport slave (
        input  exc_i, exc_cause_i, exc_pc_i,
        input  irq_i, irq_cause_i, irq_pc_i,
        output irq_ack_o,
        input  mret_i,
        input  csr_req_i, csr_we_i, csr_re_i, csr_idx_i, csr_wdata_i,
        output csr_gnt_o, csr_rdata_o,
        output cf_rd_en_o, cf_wr_en_o, cf_idx_o, cf_wdata_o,
        input  cf_rdata_i,
        output busy_o, redir_valid_o, redir_pc_o
    );

    modport master (
        output exc_i, exc_cause_i, exc_pc_i,
        output irq_i, irq_cause_i, irq_pc_i,
        input  irq_ack_o,
        output mret_i,
        output csr_req_i, csr_we_i, csr_re_i, csr_idx_i, csr_wdata_i,
        input  csr_gnt_o, csr_rdata_o,
        input  cf_rd_en_o, cf_wr_en_o, cf_idx_o, cf_wdata_o,
        output cf_rdata_i,
        input  busy_o, redir_valid_o, redir_pc_o
    );
endinterface

// File: rtl/csr_trap_seq.sv
// Trap / MRET sequencer in front of the single-port machine CSR file.
// Converts exception, interrupt and MRET events into ordered accesses to
// mstatus, mepc, mcause and mtvec, shares the CSR port with pipeline CSR
// instructions while idle, and produces the fetch redirect plus a stall.
module csr_trap_seq #(
    parameter int XLEN    = 32,
    parameter int CAUSE_W = 5,
    parameter int VEC_EN  = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    csr_trap_seq_if.slave     bus
);

    localparam logic [11:0] IDX_MSTATUS = 12'h300;
    localparam logic [11:0] IDX_MTVEC   = 12'h305;
    localparam logic [11:0] IDX_MEPC    = 12'h341;
    localparam logic [11:0] IDX_MCAUSE  = 12'h342;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RD_MST    = 3'd1,
        ST_WR_MST    = 3'd2,
        ST_WR_MEPC   = 3'd3,
        ST_WR_MCAUSE = 3'd4,
        ST_RD_MTVEC  = 3'd5,
        ST_RD_MEPC   = 3'd6,
        ST_REDIR     = 3'd7
    } state_t;

    // mstatus on trap entry: MPIE <- MIE, MIE <- 0, MPP <- M
    function automatic logic [XLEN-1:0] trap_mstatus(input logic [XLEN-1:0] mst);
        logic [XLEN-1:0] res;
        res        = mst;
        res[7]     = mst[3];
        res[3]     = 1'b0;
        res[12:11] = 2'b11;
        return res;
    endfunction

    // mstatus on MRET: MIE <- MPIE, MPIE <- 1, MPP <- M (only M-mode exists)
    function automatic logic [XLEN-1:0] mret_mstatus(input logic [XLEN-1:0] mst);
        logic [XLEN-1:0] res;
        res        = mst;
        res[3]     = mst[7];
        res[7]     = 1'b1;
        res[12:11] = 2'b11;
        return res;
    endfunction

    // mcause encoding: interrupt flag in the MSB, cause code zero-extended
    function automatic logic [XLEN-1:0] make_mcause(input logic [CAUSE_W-1:0] cause,
                                                    input logic               irq);
        logic [XLEN-1:0] res;
        res               = '0;
        res[CAUSE_W-1:0]  = cause;
        res[XLEN-1]       = irq;
        return res;
    endfunction

    // Trap vector: direct base, or base + 4*cause for vectored interrupts
    function automatic logic [XLEN-1:0] trap_target(input logic [XLEN-1:0]    mtvec,
                                                    input logic [CAUSE_W-1:0] cause,
                                                    input logic               irq);
        logic [XLEN-1:0] base;
        base = {mtvec[XLEN-1:2], 2'b00};
        if ((VEC_EN != 0) && (mtvec[1:0] == 2'b01) && irq) begin
            return base + (XLEN'(cause) << 2);
        end else begin
            return base;
        end
    endfunction

    state_t              state_r;
    state_t              next_s;
    logic                is_irq_r;
    logic                is_mret_r;
    logic [CAUSE_W-1:0]  cause_r;
    logic [XLEN-1:0]     pc_r;
    logic [XLEN-1:0]     mst_r;
    logic                redir_valid_r;
    logic [XLEN-1:0]     redir_pc_r;

    logic                event_s;
    logic                gnt_s;
    logic [XLEN-1:0]     rdata_s;
    logic                rd_en_s;
    logic                wr_en_s;
    logic [11:0]         idx_s;
    logic [XLEN-1:0]     wdata_s;
    logic                ack_s;
    logic [XLEN-1:0]     target_s;

    assign event_s = bus.exc_i | bus.irq_i | bus.mret_i;

    // Next-state decode and CSR-port steering for every state
    always_comb begin
        next_s   = state_r;
        gnt_s    = 1'b0;
        rdata_s  = '0;
        rd_en_s  = 1'b0;
        wr_en_s  = 1'b0;
        idx_s    = 12'h000;
        wdata_s  = '0;
        ack_s    = 1'b0;
        target_s = '0;
        case (state_r)
            ST_IDLE: begin
                if (event_s) begin
                    next_s = ST_RD_MST;
                end else begin
                    // Pipeline owns the port; a read-modify-write shows only the
                    // write strobe, the combinational read data is still returned.
                    gnt_s   = bus.csr_req_i;
                    idx_s   = bus.csr_idx_i;
                    wdata_s = bus.csr_wdata_i;
                    wr_en_s = bus.csr_req_i & bus.csr_we_i;
                    rd_en_s = bus.csr_req_i & bus.csr_re_i & ~bus.csr_we_i;
                    if (bus.csr_req_i && bus.csr_re_i) begin
                        rdata_s = bus.cf_rdata_i;
                    end else begin
                        rdata_s = '0;
                    end
                end
            end
            ST_RD_MST: begin
                rd_en_s = 1'b1;
                idx_s   = IDX_MSTATUS;
                if (is_irq_r && !bus.cf_rdata_i[3]) begin
                    next_s = ST_IDLE;
                end else begin
                    next_s = ST_WR_MST;
                end
            end
            ST_WR_MST: begin
                wr_en_s = 1'b1;
                idx_s   = IDX_MSTATUS;
                if (is_mret_r) begin
                    wdata_s = mret_mstatus(mst_r);
                    next_s  = ST_RD_MEPC;
                end else begin
                    wdata_s = trap_mstatus(mst_r);
                    next_s  = ST_WR_MEPC;
                end
            end
            ST_WR_MEPC: begin
                wr_en_s = 1'b1;
                idx_s   = IDX_MEPC;
                wdata_s = pc_r & ~{{(XLEN-1){1'b0}}, 1'b1};
                next_s  = ST_WR_MCAUSE;
            end
            ST_WR_MCAUSE: begin
                wr_en_s = 1'b1;
                idx_s   = IDX_MCAUSE;
                wdata_s = make_mcause(cause_r, is_irq_r);
                ack_s   = is_irq_r;
                next_s  = ST_RD_MTVEC;
            end
            ST_RD_MTVEC: begin
                rd_en_s  = 1'b1;
                idx_s    = IDX_MTVEC;
                target_s = trap_target(bus.cf_rdata_i, cause_r, is_irq_r);
                next_s   = ST_REDIR;
            end
            ST_RD_MEPC: begin
                rd_en_s  = 1'b1;
                idx_s    = IDX_MEPC;
                target_s = bus.cf_rdata_i;
                next_s   = ST_REDIR;
            end
            ST_REDIR: begin
                next_s = ST_IDLE;
            end
            default: begin
                next_s = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Capture the accepted event (exception beats interrupt beats MRET)
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            is_irq_r  <= 1'b0;
            is_mret_r <= 1'b0;
            cause_r   <= '0;
            pc_r      <= '0;
        end else if ((state_r == ST_IDLE) && event_s) begin
            is_irq_r  <= ~bus.exc_i & bus.irq_i;
            is_mret_r <= ~bus.exc_i & ~bus.irq_i & bus.mret_i;
            cause_r   <= bus.exc_i ? bus.exc_cause_i : bus.irq_cause_i;
            pc_r      <= bus.exc_i ? bus.exc_pc_i : bus.irq_pc_i;
        end else begin
            is_irq_r  <= is_irq_r;
            is_mret_r <= is_mret_r;
            cause_r   <= cause_r;
            pc_r      <= pc_r;
        end
    end

    // Latch mstatus while it is being read
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mst_r <= '0;
        end else if (state_r == ST_RD_MST) begin
            mst_r <= bus.cf_rdata_i;
        end else begin
            mst_r <= mst_r;
        end
    end

    // Registered redirect pulse; the target is zero outside the pulse
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            redir_valid_r <= 1'b0;
            redir_pc_r    <= '0;
        end else if (next_s == ST_REDIR) begin
            redir_valid_r <= 1'b1;
            redir_pc_r    <= target_s;
        end else begin
            redir_valid_r <= 1'b0;
            redir_pc_r    <= '0;
        end
    end

    // Outputs are forced low while reset is asserted, including the
    // combinational pipeline pass-through.
    assign bus.csr_gnt_o     = rst_ni & gnt_s;
    assign bus.csr_rdata_o   = rst_ni ? rdata_s : '0;
    assign bus.cf_rd_en_o    = rst_ni & rd_en_s;
    assign bus.cf_wr_en_o    = rst_ni & wr_en_s;
    assign bus.cf_idx_o      = rst_ni ? idx_s : 12'h000;
    assign bus.cf_wdata_o    = rst_ni ? wdata_s : '0;
    assign bus.irq_ack_o     = rst_ni & ack_s;
    assign bus.busy_o        = rst_ni & (state_r != ST_IDLE);
    assign bus.redir_valid_o = redir_valid_r;
    assign bus.redir_pc_o    = redir_pc_r;

endmodule
